regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised, clocked successor to the single-cycle register file, for the pipelined MIPS datapath.
- Provides NUM_RD combinational read ports, one synchronous write port, and optional write-to-read bypass.
- Keeps a per-register busy scoreboard so decode can detect load-use and other RAW hazards.
- Sits between decode (reads and busy queries) and writeback (writes and busy clears).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value.
- INIT_MODE, 1, reset contents: 0 = all zero; 1 = register i holds i, zero-extended to DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has a pending producer.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- busy_set  in  1  mark busy_addr as having an outstanding producer (issued at decode).
- busy_addr  in  ADDR_W  register to mark busy.
- busy_cnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Registers load their INIT_MODE pattern; register 0 always loads 0.
  - All busy bits clear; busy_cnt = 0.
  - Writes and busy_set are ignored in that cycle.
- Reset mid-operation: same result regardless of pending busy bits or a concurrent we.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - busy_set on it is ignored.
  - rd_busy for it is always 0.
- Write: when we=1 and wr_addr!=0, regs[wr_addr] <= wr_data at the edge. The same edge clears busy[wr_addr].
- Read, zero latency (combinational from rd_addr):
  - BYPASS=1 and we=1 and wr_addr==rd_addr[k]!=0: rd_data[k] = wr_data.
  - Otherwise rd_data[k] = regs[rd_addr[k]].
  - Multiple read ports may address the same register; each gets identical data.
- rd_busy[k]:
  - Equals busy[rd_addr[k]].
  - With BYPASS=1, forced to 0 when the same cycle's write targets that address (value is being forwarded).
  - With BYPASS=0, not forced.
- busy_set: sets busy[busy_addr] at the edge.
- Simultaneous busy_set and write to the same address: set wins and the busy bit stays 1 (a newer producer was issued). The data is still written.
- busy_set on an already-busy register: no change; busy_cnt does not double-count.
- busy_cnt:
  - Registered popcount of the busy bits, updated at the edge together with them.
  - Range 0..2**ADDR_W-1.
  - Net change per edge is in {-1, 0, +1}.
- A write to a non-busy register is legal; the busy bit stays 0.
- No clock-gating or enable beyond we and busy_set.

Decomposition:
- Shared package regfile_pkg holds:
  - INIT_ZERO / INIT_INDEX constants for INIT_MODE.
  - Default DATA_W/ADDR_W.
  - Helper function for slicing a packed port index.
- One natural sub-module: regfile_busy_tracker. It owns the busy bit vector, the set/clear priority and busy_cnt.
- The storage array and read/bypass muxing stay in the top.

Test Plan:
- Reset with INIT_MODE=1, read ports at addr 5 and 31 -> rd_data = 5 and 31. Register 0 reads 0. busy_cnt = 0.
- we=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr[0]=7 in the same cycle:
  - BYPASS=1: 0xDEADBEEF immediately.
  - BYPASS=0: old value 7 that cycle, then 0xDEADBEEF the next cycle.
- Write 0xFFFFFFFF to register 0, then read it -> 0. busy_set at addr 0 -> rd_busy=0 and busy_cnt stays 0.
- busy_set addr 3 -> next cycle rd_busy=1 for addr 3 and busy_cnt=1. Write addr 3 -> busy clears and busy_cnt=0. With BYPASS=1, rd_busy=0 already in the write cycle.
- busy_set addr 9 and we to addr 9 in the same cycle -> data is written, busy[9] stays 1, busy_cnt=1. busy_set 9 again -> busy_cnt stays 1.
- Set busy on addr 2, 4 and 6, write addr 8 (value 0x1234), then assert rst -> all busy clear, busy_cnt=0, addr 8 reads 8 (INIT_MODE=1).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined register file and its busy scoreboard.
package regfile_pkg;
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Low bit of port k inside a packed multi-port bus whose fields are w bits wide.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register outstanding-producer bits with a registered popcount; set beats clear.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_set,
    input  logic [ADDR_W-1:0]       i_set_addr,
    input  logic                    i_clr,
    input  logic [ADDR_W-1:0]       i_clr_addr,
    output logic [(2**ADDR_W)-1:0]  o_busy,
    output logic [ADDR_W:0]         o_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_cnt;
    logic             w_set, w_clr, w_inc, w_dec;

    // Register 0 never becomes busy, so both set and clear ignore it.
    always_comb begin
        w_set = i_set && (i_set_addr != '0);
        w_clr = i_clr && (i_clr_addr != '0);
        w_inc = w_set && !r_busy[i_set_addr];
        w_dec = w_clr && r_busy[i_clr_addr] && !(w_set && (i_set_addr == i_clr_addr));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_clr) r_busy[i_clr_addr] <= 1'b0;
            if (w_set) r_busy[i_set_addr] <= 1'b1;
            r_cnt <= r_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        end
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read, single-write register file with optional write-to-read bypass and a busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_RD    = 2,
    parameter bit BYPASS    = 1'b1,
    parameter int INIT_MODE = INIT_INDEX
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_busy_set,
    input  logic [ADDR_W-1:0]        i_busy_addr,
    output logic [ADDR_W:0]          o_busy_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr_ok;

    assign w_wr_ok = i_we && (i_wr_addr != '0);

    // Register 0 is never written, so it holds its reset zero forever.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= (INIT_MODE == INIT_INDEX && i != 0) ? DATA_W'(i) : '0;
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    regfile_busy_tracker #(.ADDR_W(ADDR_W)) u_busy (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set      (i_busy_set),
        .i_set_addr (i_busy_addr),
        .i_clr      (i_we),
        .i_clr_addr (i_wr_addr),
        .o_busy     (w_busy),
        .o_cnt      (o_busy_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        assign w_addr = i_rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
        // A matching same-cycle write is forwarded, so its value is not pending any more.
        assign w_hit  = BYPASS && w_wr_ok && (i_wr_addr == w_addr);
        assign o_rd_data[port_lo(k, DATA_W) +: DATA_W] = w_hit ? i_wr_data : r_regs[w_addr];
        assign o_rd_busy[k] = w_busy[w_addr] && !w_hit;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a bypass and a non-bypass instance share stimulus and are checked against an array model.
module tb_regfile_scoreboard;
    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic            we, busy_set;
    logic [AW-1:0]   wr_addr, busy_addr;
    logic [DW-1:0]   wr_data;
    logic [NR*DW-1:0] d1, d0;
    logic [NR-1:0]   b1, b0;
    logic [AW:0]     c1, c0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1), .INIT_MODE(1)) dut_byp (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(d1), .o_rd_busy(b1),
        .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_busy_set(busy_set), .i_busy_addr(busy_addr), .o_busy_cnt(c1));

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0), .INIT_MODE(1)) dut_nob (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(d0), .o_rd_busy(b0),
        .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_busy_set(busy_set), .i_busy_addr(busy_addr), .o_busy_cnt(c0));

    typedef struct {
        logic [NR*DW-1:0] d1, d0;
        logic [NR-1:0]    b1, b0;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t expq[$];
    int checks = 0, failures = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every driven cycle presents combinational outputs; compare mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("rd_data_byp", d1, e.d1);
            chk("rd_data_nob", d0, e.d0);
            chk("rd_busy_byp", {{(NR*DW-NR){1'b0}}, b1}, {{(NR*DW-NR){1'b0}}, e.b1});
            chk("rd_busy_nob", {{(NR*DW-NR){1'b0}}, b0}, {{(NR*DW-NR){1'b0}}, e.b0});
            chk("busy_cnt_byp", {{(NR*DW-AW-1){1'b0}}, c1}, {{(NR*DW-AW-1){1'b0}}, e.cnt});
            chk("busy_cnt_nob", {{(NR*DW-AW-1){1'b0}}, c0}, {{(NR*DW-AW-1){1'b0}}, e.cnt});
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = (i == 0) ? '0 : DW'(i);
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus (we are just after a rising edge), queue the expectation, advance the model.
    task automatic drive(input bit r, input bit w, input int wa, input logic [DW-1:0] wd,
                         input bit bs, input int ba, input int a0, input int a1);
        exp_t e;
        int   ad [NR];
        int   n;
        rst = r; we = w; wr_addr = AW'(wa); wr_data = wd;
        busy_set = bs; busy_addr = AW'(ba);
        ad[0] = a0; ad[1] = a1;
        rd_addr = {AW'(a1), AW'(a0)};
        n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
        e.cnt = (AW+1)'(n);
        for (int k = 0; k < NR; k++) begin
            logic [DW-1:0] stored;
            bit fwd;
            stored = (ad[k] == 0) ? '0 : m_regs[ad[k]];
            fwd    = w && (wa == ad[k]) && (ad[k] != 0);
            e.d0[k*DW +: DW] = stored;
            e.d1[k*DW +: DW] = fwd ? wd : stored;
            e.b0[k] = (ad[k] != 0) && m_busy[ad[k]];
            e.b1[k] = (ad[k] != 0) && m_busy[ad[k]] && !fwd;
        end
        expq.push_back(e);
        if (r) model_reset();
        else begin
            if (w && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
            if (bs && ba != 0) m_busy[ba] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
        busy_set = 1'b0; busy_addr = '0; rd_addr = '0;
        @(posedge clk); #1;
        model_reset();

        // Reset contents and register 0.
        drive(0, 0, 0, 0, 0, 0, 5, 31);
        drive(0, 0, 0, 0, 0, 0, 0, 5);
        // Same-cycle write with read of the same register, then next cycle.
        drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 6);
        // Register 0 ignores writes and busy_set.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3);
        // Busy set then cleared by a write.
        drive(0, 0, 0, 0, 1, 3, 3, 0);
        drive(0, 1, 3, 32'h0000_0033, 0, 0, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 3, 9);
        // Set and write together: set wins; re-set does not double-count.
        drive(0, 1, 9, 32'h0000_0099, 1, 9, 9, 3);
        drive(0, 0, 0, 0, 1, 9, 9, 9);
        drive(0, 0, 0, 0, 0, 0, 9, 0);
        // Several busy registers and a write, then reset with a concurrent write.
        drive(0, 0, 0, 0, 1, 2, 2, 4);
        drive(0, 0, 0, 0, 1, 4, 2, 4);
        drive(0, 1, 8, 32'h1234, 1, 6, 8, 6);
        drive(0, 0, 0, 0, 0, 0, 8, 6);
        drive(1, 1, 8, 32'h5555, 1, 10, 8, 2);
        drive(0, 0, 0, 0, 0, 0, 8, 2);
        // Clear and set of different registers in the same cycle.
        drive(0, 0, 0, 0, 1, 12, 12, 13);
        drive(0, 1, 12, 32'hA5A5, 1, 13, 12, 13);
        drive(0, 0, 0, 0, 0, 0, 12, 13);

        // Randomized traffic with a narrow address window for frequent collisions.
        for (int n = 0; n < 600; n++) begin
            int lim;
            lim = (n < 300) ? 7 : 31;
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, lim),
                  $urandom, $urandom_range(0, 1), $urandom_range(0, lim),
                  $urandom_range(0, lim), $urandom_range(0, lim));
        end

        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
